// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t  : arbiter FSM states (ABORT is reachable only when the
//                  WB_ARB_TIMEOUT_EN build option is defined)
//   CTI_*        : Wishbone cycle-type identifiers seen on the buses
//   M0_IDX/M1_IDX: master index encoding used by the round-robin pointer
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2,
    ABORT  = 2'd3
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Master 0 is the CPU iBus, master 1 the CPU dBus.
  localparam logic M0_IDX = 1'b0;
  localparam logic M1_IDX = 1'b1;

endpackage

// File: rtl/wishbone_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// wishbone_bus_arbiter_if
// One Wishbone classic / registered-feedback port.
//   Request  (master -> slave): cyc, stb, we, adr, dat_mosi, sel, cti, bte
//   Response (slave -> master): ack, err, dat_miso
// Modports:
//   master : the side that issues requests (CPU bus, or arbiter downstream)
//   slave  : the side that answers requests (arbiter upstream, or memory)
// -----------------------------------------------------------------------------
interface wishbone_bus_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) ();

  logic                cyc;
  logic                stb;
  logic                we;
  logic [ADDR_W-1:0]   adr;
  logic [DATA_W-1:0]   dat_mosi;
  logic [DATA_W/8-1:0] sel;
  logic [2:0]          cti;
  logic [1:0]          bte;
  logic                ack;
  logic                err;
  logic [DATA_W-1:0]   dat_miso;

  modport master (
    output cyc, stb, we, adr, dat_mosi, sel, cti, bte,
    input  ack, err, dat_miso
  );

  modport slave (
    input  cyc, stb, we, adr, dat_mosi, sel, cti, bte,
    output ack, err, dat_miso
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// -----------------------------------------------------------------------------
// wb_timeout_counter
// Counts consecutive stalled slave cycles for the arbiter watchdog. Only
// present when WB_ARB_TIMEOUT_EN is defined.
//   clk, reset_n : clock and asynchronous active-low reset
//   enable       : a stalled cycle (stb high, no ack, no err)
//   clear        : restart counting; has priority over enable
//   expired      : count has reached TIMEOUT_CYCLES-1, i.e. the current
//                  cycle is the TIMEOUT_CYCLES-th stalled cycle
// -----------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/wishbone_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_bus_arbiter
// Two-master, one-slave Wishbone arbiter placed directly after the CPU
// wrapper. Master 0 = iBus, master 1 = dBus. Contention is resolved
// round-robin; a grant is held for the whole CYC so CTI bursts stay intact.
// The grant is registered (one cycle of arbitration latency); once granted,
// requests and responses pass through combinationally.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   m0       : iBus upstream port (arbiter acts as its slave)
//   m1       : dBus upstream port (arbiter acts as its slave)
//   s        : downstream port to the shared interconnect
//
// Build option:
//   WB_ARB_TIMEOUT_EN : when defined, an access stalled for TIMEOUT_CYCLES
//                       cycles is terminated towards the owner with a
//                       one-cycle err, the slave side is idled, and the
//                       arbiter waits in ABORT until the owner drops cyc.
// -----------------------------------------------------------------------------
module wishbone_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  wishbone_bus_arbiter_if.slave  m0,
  wishbone_bus_arbiter_if.slave  m1,
  wishbone_bus_arbiter_if.master s
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wishbone_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t state;
  logic       last_grant;

  logic in_own;
  logic owner_m1;
  logic owner_cyc;
  logic owner_stb;
  logic timeout_hit;

  // ---------------------------------------------------------------------------
  // Owner decode. In ABORT the owner is the master that timed out, which was
  // recorded in last_grant when ABORT was entered.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_own    = (state == OWN_M0) || (state == OWN_M1);
    owner_m1  = (state == OWN_M1) || ((state == ABORT) && (last_grant == M1_IDX));
    owner_cyc = owner_m1 ? m1.cyc : m0.cyc;
    owner_stb = owner_m1 ? m1.stb : m0.stb;
  end

  // ---------------------------------------------------------------------------
  // Stall watchdog
  // ---------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
  logic stall;
  logic wd_clear;
  logic expired;

  // A stalled cycle is a live strobe from the owner with no termination.
  assign stall    = in_own && owner_cyc && owner_stb && !s.ack && !s.err;
  // A terminating s_ack in the timeout cycle keeps stall low, so ack wins.
  assign timeout_hit = stall && expired;
  // Any termination or any state change restarts the count.
  assign wd_clear = !in_own || !owner_cyc || s.ack || s.err || timeout_hit;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (stall),
    .clear   (wd_clear),
    .expired (expired)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      // Pointing at M1 makes M0 win the first tie after reset.
      last_grant <= M1_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (m0.cyc && (!m1.cyc || (last_grant == M1_IDX))) begin
            state <= OWN_M0;
          end else if (m1.cyc) begin
            state <= OWN_M1;
          end
        end

        // The other master's cyc is ignored here: the grant lasts until the
        // owner drops cyc, which keeps incrementing bursts unsplit.
        OWN_M0, OWN_M1: begin
          if (!owner_cyc) begin
            state      <= IDLE;
            last_grant <= owner_m1 ? M1_IDX : M0_IDX;
          end else if (timeout_hit) begin
            state      <= ABORT;
            last_grant <= owner_m1 ? M1_IDX : M0_IDX;
          end
        end

`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          if (!owner_cyc) begin
            state <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Request path: copy of the owner's request while a grant is active, all
  // zero in IDLE and ABORT.
  // ---------------------------------------------------------------------------
  logic                req_cyc;
  logic                req_stb;
  logic                req_we;
  logic [ADDR_W-1:0]   req_adr;
  logic [DATA_W-1:0]   req_dat;
  logic [DATA_W/8-1:0] req_sel;
  logic [2:0]          req_cti;
  logic [1:0]          req_bte;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    req_cyc = 1'b0;
    req_stb = 1'b0;
    req_we  = 1'b0;
    req_adr = '0;
    req_dat = '0;
    req_sel = '0;
    req_cti = CTI_CLASSIC;
    req_bte = '0;
    if (in_own) begin
      req_cyc = owner_cyc;
      req_stb = owner_stb;
      if (owner_m1) begin
        req_we  = m1.we;
        req_adr = m1.adr;
        req_dat = m1.dat_mosi;
        req_sel = m1.sel;
        req_cti = m1.cti;
        req_bte = m1.bte;
      end else begin
        req_we  = m0.we;
        req_adr = m0.adr;
        req_dat = m0.dat_mosi;
        req_sel = m0.sel;
        req_cti = m0.cti;
        req_bte = m0.bte;
      end
    end
  end

  assign s.cyc      = req_cyc;
  assign s.stb      = req_stb;
  assign s.we       = req_we;
  assign s.adr      = req_adr;
  assign s.dat_mosi = req_dat;
  assign s.sel      = req_sel;
  assign s.cti      = req_cti;
  assign s.bte      = req_bte;

  // ---------------------------------------------------------------------------
  // Response path: only the owner sees terminations; read data is broadcast
  // because a non-owner never sees an ack that would qualify it.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rsp_dat;
  logic              m0_ack_c;
  logic              m0_err_c;
  logic              m1_ack_c;
  logic              m1_err_c;

  always_comb begin
    m0_ack_c = 1'b0;
    m0_err_c = 1'b0;
    m1_ack_c = 1'b0;
    m1_err_c = 1'b0;
    if (in_own) begin
      if (owner_m1) begin
        m1_ack_c = s.ack;
        m1_err_c = s.err || timeout_hit;
      end else begin
        m0_ack_c = s.ack;
        m0_err_c = s.err || timeout_hit;
      end
    end
  end

  assign rsp_dat     = s.dat_miso;
  assign m0.ack      = m0_ack_c;
  assign m0.err      = m0_err_c;
  assign m0.dat_miso = rsp_dat;
  assign m1.ack      = m1_ack_c;
  assign m1.err      = m1_err_c;
  assign m1.dat_miso = rsp_dat;

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wishbone_bus_arbiter
// Self-checking bench for wishbone_bus_arbiter: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Watchdog scenarios are built when WB_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_wishbone_bus_arbiter;
  import wb_arb_pkg::*;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int TO     = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wishbone_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  wishbone_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
  wishbone_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

  wishbone_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .m0(m0_bus), .m1(m1_bus), .s(s_bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic cyc, input logic we,
                         input logic [ADDR_W-1:0] adr, input logic [2:0] cti,
                         input logic [DATA_W-1:0] dat);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = cyc; m0_bus.we = we; m0_bus.adr = adr;
      m0_bus.dat_mosi = dat; m0_bus.sel = '1; m0_bus.cti = cti; m0_bus.bte = 2'b00;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = cyc; m1_bus.we = we; m1_bus.adr = adr;
      m1_bus.dat_mosi = dat; m1_bus.sel = '1; m1_bus.cti = cti; m1_bus.bte = 2'b00;
    end
  endtask

  task automatic clear_inputs();
    set_req(0, 1'b0, 1'b0, '0, CTI_CLASSIC, '0);
    set_req(1, 1'b0, 1'b0, '0, CTI_CLASSIC, '0);
    s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.dat_miso = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic mcyc(int m);
    return (m == 1) ? m1_bus.cyc : m0_bus.cyc;
  endfunction
  function automatic logic mstb(int m);
    return (m == 1) ? m1_bus.stb : m0_bus.stb;
  endfunction
  function automatic logic [ADDR_W-1:0] madr(int m);
    return (m == 1) ? m1_bus.adr : m0_bus.adr;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 30'h55, CTI_CLASSIC, '0);
    s_bus.ack = 1'b1;
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b0) begin mismatched++; $display("FAIL reset_s_cyc: got %b expected 0", s_bus.cyc); end
    compared++; if (s_bus.adr !== '0) begin mismatched++; $display("FAIL reset_s_adr: got %h expected 0", s_bus.adr); end
    compared++; if (m0_bus.ack !== 1'b0) begin mismatched++; $display("FAIL reset_m0_ack: got %b expected 0", m0_bus.ack); end
    tick();
    clear_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    compared++; if ({s_bus.cyc, s_bus.stb, m0_bus.ack, m1_bus.ack} !== 4'b0000) begin mismatched++; $display("FAIL reset_idle: got %b expected 0000", {s_bus.cyc, s_bus.stb, m0_bus.ack, m1_bus.ack}); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_read();
    do_reset();
    set_req(0, 1'b1, 1'b0, 30'h0000100, CTI_CLASSIC, '0);
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b0) begin mismatched++; $display("FAIL single_latency: got s_cyc=%b expected 0", s_bus.cyc); end
    tick();
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b1 || s_bus.adr !== 30'h0000100) begin mismatched++; $display("FAIL single_grant: got cyc=%b adr=%h expected 1/0000100", s_bus.cyc, s_bus.adr); end
    tick();
    s_bus.ack = 1'b1; s_bus.dat_miso = 32'hDEADBEEF;
    @(negedge clk);
    compared++; if (m0_bus.ack !== 1'b1 || m0_bus.dat_miso !== 32'hDEADBEEF) begin mismatched++; $display("FAIL single_ack: got ack=%b dat=%h expected 1/deadbeef", m0_bus.ack, m0_bus.dat_miso); end
    compared++; if (m1_bus.ack !== 1'b0) begin mismatched++; $display("FAIL single_m1_ack: got %b expected 0", m1_bus.ack); end
    tick();
    clear_inputs();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    do_reset();
    set_req(0, 1'b1, 1'b0, 30'h10, CTI_CLASSIC, '0);
    set_req(1, 1'b1, 1'b1, 30'h20, CTI_CLASSIC, 32'h1234);
    tick();
    s_bus.ack = 1'b1;
    @(negedge clk);
    compared++; if (s_bus.adr !== 30'h10 || m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin mismatched++; $display("FAIL rr_first_m0: got adr=%h ack0=%b ack1=%b expected 10/1/0", s_bus.adr, m0_bus.ack, m1_bus.ack); end
    tick();
    s_bus.ack = 1'b0;
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
    tick();
    // M0 asks again at once, forming a second contended pair
    set_req(0, 1'b1, 1'b0, 30'h11, CTI_CLASSIC, '0);
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b0) begin mismatched++; $display("FAIL rr_idle_gap: got s_cyc=%b expected 0", s_bus.cyc); end
    tick();
    s_bus.ack = 1'b1;
    @(negedge clk);
    compared++; if (s_bus.adr !== 30'h20 || s_bus.we !== 1'b1 || m1_bus.ack !== 1'b1 || m0_bus.ack !== 1'b0) begin mismatched++; $display("FAIL rr_then_m1: got adr=%h we=%b ack1=%b ack0=%b expected 20/1/1/0", s_bus.adr, s_bus.we, m1_bus.ack, m0_bus.ack); end
    tick();
    s_bus.ack = 1'b0;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
    tick();
    tick();
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b1 || s_bus.adr !== 30'h11) begin mismatched++; $display("FAIL rr_m0_second: got cyc=%b adr=%h expected 1/11", s_bus.cyc, s_bus.adr); end
    tick();
    clear_inputs();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_burst();
    logic [2:0] cti;
    do_reset();
    set_req(1, 1'b1, 1'b1, 30'h200, CTI_INCR, 32'hA0);
    tick();
    set_req(0, 1'b1, 1'b0, 30'h300, CTI_CLASSIC, '0);
    for (int b = 0; b < 4; b++) begin
      cti = (b == 3) ? CTI_END : CTI_INCR;
      set_req(1, 1'b1, 1'b1, 30'h200 + 30'(b), cti, 32'hA0 + 32'(b));
      s_bus.ack = 1'b1;
      @(negedge clk);
      compared++; if (s_bus.cyc !== 1'b1 || s_bus.adr !== 30'h200 + 30'(b) || s_bus.cti !== cti || s_bus.dat_mosi !== 32'hA0 + 32'(b)) begin mismatched++; $display("FAIL burst_beat%0d: got cyc=%b adr=%h cti=%b dat=%h expected 1/%h/%b/%h", b, s_bus.cyc, s_bus.adr, s_bus.cti, s_bus.dat_mosi, 30'h200 + 30'(b), cti, 32'hA0 + 32'(b)); end
      compared++; if (m1_bus.ack !== 1'b1 || m0_bus.ack !== 1'b0) begin mismatched++; $display("FAIL burst_ack%0d: got ack1=%b ack0=%b expected 1/0", b, m1_bus.ack, m0_bus.ack); end
      tick();
    end
    s_bus.ack = 1'b0;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b0) begin mismatched++; $display("FAIL burst_release: got s_cyc=%b expected 0", s_bus.cyc); end
    tick();
    tick();
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b1 || s_bus.adr !== 30'h300) begin mismatched++; $display("FAIL burst_m0_after: got cyc=%b adr=%h expected 1/300", s_bus.cyc, s_bus.adr); end
    tick();
    clear_inputs();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    do_reset();
    set_req(1, 1'b1, 1'b0, 30'h40, CTI_CLASSIC, '0);
    tick();
    s_bus.ack = 1'b1;
    tick();
    s_bus.ack = 1'b0;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
    tick();
    set_req(1, 1'b1, 1'b0, 30'h41, CTI_CLASSIC, '0);
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_gap: got s_cyc=%b expected 0", s_bus.cyc); end
    tick();
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b1 || s_bus.adr !== 30'h41) begin mismatched++; $display("FAIL b2b_regrant: got cyc=%b adr=%h expected 1/41", s_bus.cyc, s_bus.adr); end
    // abandon the access: cyc drops, stb left high, no ack
    tick();
    m1_bus.cyc = 1'b0;
    tick();
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b0 || m1_bus.err !== 1'b0 || m0_bus.err !== 1'b0) begin mismatched++; $display("FAIL b2b_abandon: got cyc=%b err1=%b err0=%b expected 0/0/0", s_bus.cyc, m1_bus.err, m0_bus.err); end
    clear_inputs();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_write();
    do_reset();
    set_req(1, 1'b1, 1'b1, 30'h77, CTI_CLASSIC, 32'hCAFE);
    tick();
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b1 || s_bus.we !== 1'b1) begin mismatched++; $display("FAIL rstmid_pre: got cyc=%b we=%b expected 1/1", s_bus.cyc, s_bus.we); end
    #2;
    reset_n = 1'b0;
    s_bus.ack = 1'b1;
    #1;
    compared++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin mismatched++; $display("FAIL rstmid_drop: got cyc=%b stb=%b expected 0/0", s_bus.cyc, s_bus.stb); end
    compared++; if ({m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err} !== 4'b0000) begin mismatched++; $display("FAIL rstmid_resp: got %b expected 0000", {m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err}); end
    clear_inputs();
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b0) begin mismatched++; $display("FAIL rstmid_after: got s_cyc=%b expected 0", s_bus.cyc); end
    tick();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    do_reset();
    set_req(0, 1'b1, 1'b0, 30'h900, CTI_CLASSIC, '0);
    tick();
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      compared++; if (s_bus.cyc !== 1'b1 || m0_bus.err !== (k == TO)) begin mismatched++; $display("FAIL timeout_stall%0d: got cyc=%b err=%b expected 1/%b", k, s_bus.cyc, m0_bus.err, (k == TO)); end
      tick();
    end
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0 || m0_bus.err !== 1'b0) begin mismatched++; $display("FAIL timeout_abort: got cyc=%b stb=%b err=%b expected 0/0/0", s_bus.cyc, s_bus.stb, m0_bus.err); end
    tick();
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
    set_req(1, 1'b1, 1'b0, 30'hA00, CTI_CLASSIC, '0);
    tick();
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b0) begin mismatched++; $display("FAIL timeout_exit: got s_cyc=%b expected 0", s_bus.cyc); end
    tick();
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b1 || s_bus.adr !== 30'hA00) begin mismatched++; $display("FAIL timeout_regrant: got cyc=%b adr=%h expected 1/a00", s_bus.cyc, s_bus.adr); end
    clear_inputs();
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ack_on_timeout();
    do_reset();
    set_req(0, 1'b1, 1'b0, 30'hB00, CTI_CLASSIC, '0);
    tick();
    repeat (TO - 1) tick();
    s_bus.ack = 1'b1;
    @(negedge clk);
    compared++; if (m0_bus.ack !== 1'b1 || m0_bus.err !== 1'b0) begin mismatched++; $display("FAIL ackwin_resp: got ack=%b err=%b expected 1/0", m0_bus.ack, m0_bus.err); end
    tick();
    s_bus.ack = 1'b0;
    @(negedge clk);
    compared++; if (s_bus.cyc !== 1'b1 || m0_bus.err !== 1'b0) begin mismatched++; $display("FAIL ackwin_no_abort: got cyc=%b err=%b expected 1/0", s_bus.cyc, m0_bus.err); end
    clear_inputs();
    tick();
    tick();
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Randomized traffic against a behavioural model: the model tracks who holds
  // the bus (or -1), the previous winner, and the length of the current stall.
  // ---------------------------------------------------------------------------
  task automatic test_random();
    int owner, last, stall;
    bit abort;
    bit busy [2];
    bit term [2];
    bit term_err [2];
    logic exp_cyc, exp_stb, exp_to;
    logic [ADDR_W-1:0] exp_adr;
    logic [1:0] exp_ack, exp_err;
    do_reset();
    owner = -1; last = 1; stall = 0; abort = 1'b0;
    busy = '{1'b0, 1'b0}; term = '{1'b0, 1'b0}; term_err = '{1'b0, 1'b0};
    for (int n = 0; n < 800; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!busy[m]) begin
          if ($urandom_range(0, 3) == 0) begin
            busy[m] = 1'b1;
            set_req(m, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom), CTI_CLASSIC, $urandom);
          end
        end else if (term[m]) begin
          if (term_err[m] || $urandom_range(0, 1) == 0) begin
            busy[m] = 1'b0;
            set_req(m, 1'b0, 1'b0, '0, CTI_CLASSIC, '0);
          end else begin
            set_req(m, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom), CTI_CLASSIC, $urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          busy[m] = 1'b0;
          set_req(m, 1'b0, 1'b0, '0, CTI_CLASSIC, '0);
        end
      end
      s_bus.ack      = ($urandom_range(0, 2) == 0);
      s_bus.err      = !s_bus.ack && ($urandom_range(0, 24) == 0);
      s_bus.dat_miso = $urandom;
      @(negedge clk);

      exp_cyc = 1'b0; exp_stb = 1'b0; exp_adr = '0; exp_ack = '0; exp_err = '0; exp_to = 1'b0;
      if (owner >= 0 && !abort) begin
        exp_cyc = mcyc(owner);
        exp_stb = mstb(owner);
        exp_adr = madr(owner);
        exp_to  = TO_EN && exp_cyc && exp_stb && !s_bus.ack && !s_bus.err && (stall == TO - 1);
        exp_ack[owner] = s_bus.ack;
        exp_err[owner] = s_bus.err || exp_to;
      end
      compared++; if ({s_bus.cyc, s_bus.stb} !== {exp_cyc, exp_stb}) begin mismatched++; $display("FAIL rand_req@%0d: got cyc/stb=%b expected %b", n, {s_bus.cyc, s_bus.stb}, {exp_cyc, exp_stb}); end
      compared++; if (s_bus.adr !== exp_adr) begin mismatched++; $display("FAIL rand_adr@%0d: got %h expected %h", n, s_bus.adr, exp_adr); end
      compared++; if ({m1_bus.ack, m0_bus.ack} !== exp_ack) begin mismatched++; $display("FAIL rand_ack@%0d: got %b expected %b", n, {m1_bus.ack, m0_bus.ack}, exp_ack); end
      compared++; if ({m1_bus.err, m0_bus.err} !== exp_err) begin mismatched++; $display("FAIL rand_err@%0d: got %b expected %b", n, {m1_bus.err, m0_bus.err}, exp_err); end
      compared++; if (m0_bus.dat_miso !== s_bus.dat_miso || m1_bus.dat_miso !== s_bus.dat_miso) begin mismatched++; $display("FAIL rand_rdata@%0d: got %h/%h expected %h", n, m0_bus.dat_miso, m1_bus.dat_miso, s_bus.dat_miso); end

      term[0] = m0_bus.ack || m0_bus.err; term_err[0] = m0_bus.err;
      term[1] = m1_bus.ack || m1_bus.err; term_err[1] = m1_bus.err;

      if (owner < 0) begin
        if (mcyc(0) && mcyc(1)) owner = 1 - last;
        else if (mcyc(0))       owner = 0;
        else if (mcyc(1))       owner = 1;
        stall = 0;
      end else if (abort) begin
        if (!mcyc(owner)) begin owner = -1; abort = 1'b0; end
      end else if (!mcyc(owner)) begin
        last = owner; owner = -1;
      end else if (exp_to) begin
        abort = 1'b1; last = owner;
      end else if (s_bus.ack || s_bus.err) begin
        stall = 0;
      end else if (mstb(owner)) begin
        stall++;
      end
      tick();
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst();
    test_back_to_back();
    test_reset_mid_write();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
    test_ack_on_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wishbone_bus_arbiter.md
Name: wishbone_bus_arbiter

Overview:
- Two-master, one-slave Wishbone classic/registered-feedback arbiter that sits directly downstream of the CPU wrapper.
- Master 0 is the CPU iBus and master 1 is the CPU dBus; the single slave port drives the shared memory/peripheral interconnect.
- Grants round-robin on contention and holds the grant for a whole CYC, so CTI bursts are never split.
- Optionally aborts stalled slave accesses with ERR so a hung peripheral cannot lock up the CPU.

Parameters:
- ADDR_W, 30, word-address width of all ports.
- DATA_W, 32, data width; SEL width is DATA_W/8.
- TIMEOUT_CYCLES, 255, stall cycles before abort (used only with the optional feature); minimum 2.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_cyc / m0_stb / m0_we  in  1 each  iBus request controls.
- m0_adr / m0_dat_mosi / m0_sel  in  ADDR_W / DATA_W / DATA_W/8  iBus address, write data, byte select.
- m0_cti / m0_bte  in  3 / 2  iBus cycle type and burst type.
- m0_ack / m0_err  out  1 each  iBus termination.
- m0_dat_miso  out  DATA_W  iBus read data.
- m1_*  same set and widths as m0_*  dBus.
- s_cyc / s_stb / s_we  out  1 each  slave request controls.
- s_adr / s_dat_mosi / s_sel / s_cti / s_bte  out  same widths as m0_*  slave request fields.
- s_ack / s_err  in  1 each  slave termination.
- s_dat_miso  in  DATA_W  slave read data.

Behaviour:
- State machine states: IDLE, OWN_M0, OWN_M1, plus ABORT with the feature enabled. A last_grant register selects the round-robin winner.
- Reset values: state=IDLE, last_grant=M1 (so M0 wins the first tie), timeout counter 0. While in IDLE, every s_* output is 0 and m0/m1 ack/err are 0.
- Async reset asserted mid-transaction: state returns to IDLE immediately and s_cyc/s_stb drop immediately. No ack is delivered for the interrupted access.
- IDLE transitions:
  - only m0_cyc high -> OWN_M0.
  - only m1_cyc high -> OWN_M1.
  - both high -> grant the master that is not last_grant.
  - The grant is registered, so s_cyc first rises 1 cycle after the master raises cyc (arbitration latency 1).
- OWN_Mx:
  - All s_* request fields are a combinational copy of mx_*; s_cyc = mx_cyc.
  - mx_ack = s_ack and mx_err = s_err, combinationally (zero added response latency).
  - The non-owner sees ack=0 and err=0.
  - m0_dat_miso and m1_dat_miso both carry s_dat_miso unconditionally.
- Leaving OWN_Mx: on the cycle mx_cyc is sampled low, go to IDLE and set last_grant=x. A pending request from the other master is granted from IDLE on the next edge.
- A request from the other master never pre-empts the owner, including during incrementing bursts (CTI=010) until CTI=111 and cyc drops.
- The owner dropping cyc with stb still high and no ack is legal: the arbiter returns to IDLE with no error.
- Back-to-back requests from the same master with no competitor: the master is re-granted, with one IDLE cycle between them.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - The counter increments each cycle in OWN_Mx with s_stb=1, s_ack=0, s_err=0. It clears on ack, on err, or on any state change.
  - When the count equals TIMEOUT_CYCLES-1 and no ack/err is present, the arbiter asserts mx_err for exactly 1 cycle, forces s_cyc=s_stb=0 from the next cycle on, and enters ABORT.
  - ABORT holds the slave idle and drives no ack/err until mx_cyc is low, then goes to IDLE with last_grant=x.
  - An s_ack arriving in the same cycle as the timeout wins: normal ack, no err.
- Without the macro: no counter and no ABORT state; err comes only from s_err.

Decomposition:
- Shared package wb_arb_pkg holds:
  - the state typedef (IDLE/OWN_M0/OWN_M1/ABORT);
  - the CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111;
  - the master index localparams.
- One sub-module is natural: wb_timeout_counter (enable, clear, expired), instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- Single iBus read: m0 cyc/stb, adr=0x0000100, slave acks 1 cycle later with 0xDEADBEEF -> s_cyc rises 1 cycle after m0_cyc, m0_ack=1 with m0_dat_miso=0xDEADBEEF, m1_ack stays 0.
- Simultaneous requests straight out of reset -> M0 granted first; after m0_cyc drops, M1 is granted on the next edge. A second simultaneous pair is granted M1 first, M0 second (round-robin).
- dBus 4-beat incrementing burst (CTI 010,010,010,111) while m0_cyc is held high throughout -> all 4 beats reach the slave uninterrupted, and M0 is granted only after m1_cyc drops.
- Reset_n pulsed low mid-write with s_cyc=1 -> s_cyc/s_stb are 0 in the same cycle, state is IDLE, and no ack/err reaches either master.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never acks -> m0_err pulses high for exactly 1 cycle, 8 cycles after s_stb first rises; s_cyc goes low from the next cycle; a new request is granted after m0_cyc drops.
- With WB_ARB_TIMEOUT_EN, s_ack arrives exactly on the timeout cycle -> m0_ack=1, m0_err=0, no ABORT entered.
